uart_tx_cfg: RTL and testbench

Parametrised, buffered UART transmitter: a successor to the fixed 8N1, single-shot transmitter. It accepts words through a valid/ready handshake into an internal FIFO and serialises them LSB-first. Data width, parity, stop-bit count, oversample ratio and buffer depth are configurable. It sits between the host-side byte producers and the serial TX pin, and is driven by the shared baud-tick generator.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_tx_cfg.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and FSM state encoding,
// common to the transmitter and the future receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    PAR   = ST_PAR,
    STOP  = ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Word buffer in front of the UART transmitter; the head word is
// visible on rdata without waiting for a pop.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_en, pop_en;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_d  = push_en ? wr_q + AW'(1) : wr_q;
    rd_d  = pop_en ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered, parametrised UART transmitter: FIFO in, LSB-first frame
// out with optional parity and one or two stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        baud_tick,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        bit_out,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 2) begin : g_bad_os
    $error("uart_tx_cfg: OVERSAMPLE must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  tx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 bit_q, bit_d;
  logic                 done_q, done_d;

  logic                 pop, load, bit_end, full, empty;
  logic [DATA_BITS-1:0] head;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign in_ready = !full;
  assign bit_out  = bit_q;
  assign busy     = (state_q != IDLE);
  assign tx_done  = done_q;
  assign bit_end  = baud_tick && (tick_q == TW'(OVERSAMPLE - 1));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    load    = 1'b0;
    if (state_q != IDLE && baud_tick) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end
    unique case (state_q)
      IDLE: load = !empty;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
            bit_d   = (PARITY != PAR_NONE) ? par_q : 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = shift_q[1];
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == IW'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
            load    = !empty;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Parity is frozen from the word as popped, before any shifting.
    if (load) begin
      state_d = START;
      shift_d = head;
      par_d   = (^head) ^ (PARITY == PAR_ODD);
      bit_d   = 1'b0;
      tick_d  = '0;
      idx_d   = '0;
    end
  end

  assign pop = load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg across five parameter sets.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  typedef struct {
    int          idx;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] frame;
    string       name;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      din = '0;
  logic [4:0]      vld = '0;
  logic [4:0]      bo, rdy, bsy, td;
  logic [4:0][2:0] cnt;
  logic            bt_fast = 1'b1;
  logic [1:0]      ph = '0;
  logic            bt_slow;

  int vecs = 0;
  int errs = 0;

  logic bo_s  [0:699];
  logic td_s  [0:699];
  logic bsy_s [0:699];

  always #5 clk = ~clk;

  always @(posedge clk) ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
  assign bt_slow = (ph == 2'd2);

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(4), .PARITY(PAR_NONE),
    .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .baud_tick(bt_fast), .in_data(din),
    .in_valid(vld[0]), .in_ready(rdy[0]), .bit_out(bo[0]),
    .busy(bsy[0]), .tx_done(td[0]), .fifo_count(cnt[0]));

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(4), .PARITY(PAR_EVEN),
    .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .baud_tick(bt_fast), .in_data(din),
    .in_valid(vld[1]), .in_ready(rdy[1]), .bit_out(bo[1]),
    .busy(bsy[1]), .tx_done(td[1]), .fifo_count(cnt[1]));

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(4), .PARITY(PAR_ODD),
    .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .reset(reset), .baud_tick(bt_fast), .in_data(din),
    .in_valid(vld[2]), .in_ready(rdy[2]), .bit_out(bo[2]),
    .busy(bsy[2]), .tx_done(td[2]), .fifo_count(cnt[2]));

  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(4), .PARITY(PAR_NONE),
    .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .reset(reset), .baud_tick(bt_fast), .in_data(din[6:0]),
    .in_valid(vld[3]), .in_ready(rdy[3]), .bit_out(bo[3]),
    .busy(bsy[3]), .tx_done(td[3]), .fifo_count(cnt[3]));

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(PAR_NONE),
    .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .reset(reset), .baud_tick(bt_slow), .in_data(din),
    .in_valid(vld[4]), .in_ready(rdy[4]), .bit_out(bo[4]),
    .busy(bsy[4]), .tx_done(td[4]), .fifo_count(cnt[4]));

  task automatic check(input string n, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d", n, got, exp);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] d);
    @(negedge clk);
    din = d;
    vld[idx] = 1'b1;
    @(posedge clk);
    #1;
    vld[idx] = 1'b0;
  endtask

  task automatic capture(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bo_s[i]  = bo[idx];
      td_s[i]  = td[idx];
      bsy_s[i] = bsy[idx];
    end
  endtask

  task automatic run_vec(input vec_t v);
    int bad, pulses, at, last;
    last = v.nbits * 4;
    push(v.idx, v.data);
    check({v.name, "_idle_after_push"}, int'(bo[v.idx]), 1);
    check({v.name, "_count_after_push"}, int'(cnt[v.idx]), 1);
    capture(v.idx, last + 2);
    bad = 0;
    for (int i = 0; i < last; i++)
      if (bo_s[i] !== v.frame[i/4]) bad++;
    check({v.name, "_bad_bit_samples"}, bad, 0);
    pulses = 0;
    at = -1;
    for (int i = 0; i < last + 2; i++)
      if (td_s[i] === 1'b1) begin
        pulses++;
        at = i;
      end
    check({v.name, "_done_pulses"}, pulses, 1);
    check({v.name, "_done_cycle"}, at, last);
    check({v.name, "_busy_in_frame"}, int'(bsy_s[0]), 1);
    check({v.name, "_busy_after"}, int'(bsy_s[last + 1]), 0);
    check({v.name, "_line_after"}, int'(bo_s[last + 1]), 1);
  endtask

  task automatic fifo_test();
    logic [7:0] w [6];
    int rdy_bad, saw_full, bad, pulses, pos_bad, f, b;
    logic e;
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rdy_bad = 0;
    saw_full = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          din = w[k];
          vld[0] = 1'b1;
          for (int g = 0; g < 400 && !rdy[0]; g++) @(negedge clk);
          @(posedge clk);
        end
        @(negedge clk);
        vld[0] = 1'b0;
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 250; i++) begin
          @(posedge clk);
          #1;
          bo_s[i]  = bo[0];
          td_s[i]  = td[0];
          bsy_s[i] = bsy[0];
          if (cnt[0] == 3'd4) saw_full = 1;
          if (rdy[0] !== (cnt[0] != 3'd4)) rdy_bad++;
        end
      end
    join
    bad = 0;
    pulses = 0;
    pos_bad = 0;
    for (int i = 1; i <= 240; i++) begin
      f = (i - 1) / 40;
      b = ((i - 1) % 40) / 4;
      e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[f][b-1];
      if (bo_s[i] !== e) bad++;
    end
    for (int i = 0; i < 250; i++)
      if (td_s[i] === 1'b1) begin
        pulses++;
        if (i % 40 != 1 || i < 41) pos_bad++;
      end
    check("fifo_saw_full", saw_full, 1);
    check("fifo_ready_vs_count", rdy_bad, 0);
    check("fifo_stream_bad_samples", bad, 0);
    check("fifo_done_pulses", pulses, 6);
    check("fifo_done_misplaced", pos_bad, 0);
    check("fifo_busy_after", int'(bsy_s[242]), 0);
  endtask

  task automatic slow_test();
    int t [8];
    int k, tdat, p, l0;
    repeat (20) @(posedge clk);
    push(4, 8'hA5);
    p = (int'(ph) + 1) % 3;
    l0 = ((2 - p + 3) % 3) + 1 + 45;
    capture(4, 600);
    check("slow_latency_line", int'(bo_s[0]), 0);
    t[0] = 0;
    k = 1;
    for (int i = 1; i < 600; i++)
      if (bo_s[i] !== bo_s[i-1] && k < 8) begin
        t[k] = i;
        k++;
      end
    check("slow_transitions", k, 8);
    tdat = -1;
    for (int i = 599; i >= 0; i--)
      if (td_s[i] === 1'b1) tdat = i;
    if (k == 8) begin
      check("slow_start_len", t[1] - t[0], l0);
      check("slow_bit0_len", t[2] - t[1], 48);
      check("slow_bit1_len", t[3] - t[2], 48);
      check("slow_bit2_len", t[4] - t[3], 48);
      check("slow_bit34_len", t[5] - t[4], 96);
      check("slow_bit5_len", t[6] - t[5], 48);
      check("slow_bit6_len", t[7] - t[6], 48);
      check("slow_bit7_stop_len", tdat - t[7], 96);
    end
  endtask

  task automatic reset_test();
    int bad;
    vec_t v;
    @(negedge clk);
    din = 8'h81;
    vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din = 8'h42;
    @(posedge clk);
    @(negedge clk);
    din = 8'h24;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (58) @(posedge clk);
    #1;
    check("rst_busy_before", int'(bsy[0]), 1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_line", int'(bo[0]), 1);
    check("rst_mid_count", int'(cnt[0]), 0);
    check("rst_mid_busy", int'(bsy[0]), 0);
    check("rst_mid_done", int'(td[0]), 0);
    check("rst_mid_ready", int'(rdy[0]), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (bo[0] !== 1'b1 || td[0] !== 1'b0 || bsy[0] !== 1'b0) bad++;
    end
    check("rst_line_stays_idle", bad, 0);
    v = '{0, 8'h3C, 10, 12'h278, "A_3c"};
    run_vec(v);
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = '{0, 8'hA5, 10, 12'h34A, "A_a5"};
    tbl[1] = '{0, 8'hFF, 10, 12'h3FE, "A_ff"};
    tbl[2] = '{0, 8'h00, 10, 12'h200, "A_00"};
    tbl[3] = '{1, 8'h07, 11, 12'h60E, "B_even_07"};
    tbl[4] = '{1, 8'h00, 11, 12'h400, "B_even_00"};
    tbl[5] = '{2, 8'h07, 11, 12'h40E, "C_odd_07"};
    tbl[6] = '{2, 8'h00, 11, 12'h600, "C_odd_00"};
    tbl[7] = '{3, 8'h41, 10, 12'h382, "D_7b2s_41"};
    tbl[8] = '{3, 8'h7F, 10, 12'h3FE, "D_7b2s_7f"};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst%0d_line", i), int'(bo[i]), 1);
      check($sformatf("rst%0d_ready", i), int'(rdy[i]), 1);
      check($sformatf("rst%0d_busy", i), int'(bsy[i]), 0);
      check($sformatf("rst%0d_done", i), int'(td[i]), 0);
      check($sformatf("rst%0d_count", i), int'(cnt[i]), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);
    fifo_test();
    slow_test();
    reset_test();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

endmodule
